// File: rtl/popcount_seq.sv
// Wide population count built from one shared 8-bit popcount stage.
// Bytes are shifted through the stage one per cycle and summed into acc.

module popcount8 (
  input  logic [7:0] b,
  output logic [3:0] cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < 8; i++) cnt = cnt + {3'b000, b[i]};
  end
endmodule

module popcount_seq #(
  parameter int N_BYTES   = 4,
  parameter int OUT_WIDTH = 6
) (
  input  logic                   CLK,
  input  logic                   ASYNCRESETN,
  input  logic [8*N_BYTES-1:0]   I,
  input  logic                   I_valid,
  output logic                   I_ready,
  output logic [OUT_WIDTH-1:0]   O,
  output logic                   O_valid,
  input  logic                   O_ready,
  output logic                   busy
);
  localparam int IW = $clog2(N_BYTES) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state, state_nxt;
  logic [8*N_BYTES-1:0]   shreg;
  logic [OUT_WIDTH-1:0]   acc;
  logic [IW-1:0]          idx;
  logic                   arm;
  logic [3:0]             cnt;
  logic                   accept;
  logic                   last;

  popcount8 u_pc8 (.b(shreg[7:0]), .cnt(cnt));

  // arm stays low through the first edge after reset release so no transfer
  // can happen on that edge.
  assign I_ready = arm && ((state == IDLE) || ((state == DONE) && O_ready));
  assign accept  = I_valid && I_ready;
  assign last    = (idx == IW'(N_BYTES - 1));
  assign O       = acc;
  assign O_valid = (state == DONE);
  assign busy    = (state == RUN);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (O_ready) state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state <= IDLE;
      arm   <= 1'b0;
    end else begin
      state <= state_nxt;
      arm   <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      shreg <= '0;
      acc   <= '0;
      idx   <= '0;
    end else if (accept) begin
      shreg <= I;
      acc   <= '0;
      idx   <= '0;
    end else if (state == RUN) begin
      acc   <= acc + OUT_WIDTH'(cnt);
      shreg <= shreg >> 8;
      idx   <= idx + IW'(1);
    end
  end
endmodule

// File: tb/tb_popcount_seq.sv
// Randomised and directed checks of popcount_seq at three parameter points
// against a $countones reference and the expected cycle timing.

module tb_popcount_seq;
  logic        CLK = 1'b0;
  logic        ASYNCRESETN = 1'b0;

  logic [31:0] I = '0;
  logic        I_valid = 1'b0, O_ready = 1'b0;
  logic        I_ready, O_valid, busy;
  logic [5:0]  O;

  logic [7:0]  I1 = '0;
  logic        I1_valid = 1'b0, O1_ready = 1'b0;
  logic        I1_ready, O1_valid, busy1;
  logic [3:0]  O1;

  logic [63:0] I8 = '0;
  logic        I8_valid = 1'b0, O8_ready = 1'b0;
  logic        I8_ready, O8_valid, busy8;
  logic [6:0]  O8;

  int n_chk = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  popcount_seq dut (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .I(I), .I_valid(I_valid),
    .I_ready(I_ready), .O(O), .O_valid(O_valid), .O_ready(O_ready), .busy(busy)
  );

  popcount_seq #(.N_BYTES(1), .OUT_WIDTH(4)) dut1 (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .I(I1), .I_valid(I1_valid),
    .I_ready(I1_ready), .O(O1), .O_valid(O1_valid), .O_ready(O1_ready), .busy(busy1)
  );

  popcount_seq #(.N_BYTES(8), .OUT_WIDTH(7)) dut8 (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .I(I8), .I_valid(I8_valid),
    .I_ready(I8_ready), .O(O8), .O_valid(O8_valid), .O_ready(O8_ready), .busy(busy8)
  );

  // Stimulus only: pushes one word through the default instance with O_ready
  // high, reporting result, edges from accept to O_valid, and busy cycles.
  task automatic run_word(input logic [31:0] w, output logic [5:0] res,
                          output int lat, output int bcyc);
    @(negedge CLK); I = w; I_valid = 1'b1; O_ready = 1'b1;
    @(posedge CLK); #1; I_valid = 1'b0; lat = 0; bcyc = 0;
    while (!O_valid && lat < 40) begin
      if (busy) bcyc++;
      @(posedge CLK); #1; lat++;
    end
    res = O;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    @(negedge CLK); I_valid = 1'b1; I = 32'hFFFF_FFFF; O_ready = 1'b1;
    repeat (2) @(posedge CLK); #1;
    n_chk++; if ({O, O_valid, busy, I_ready} !== 9'd0)
      $display("FAIL reset_outputs got O=%0d ov=%b busy=%b ir=%b exp all 0", O, O_valid, busy, I_ready);
    else n_pass++;
    n_chk++; if ({O1, O1_valid, busy1, I1_ready, O8, O8_valid, busy8, I8_ready} !== 17'd0)
      $display("FAIL reset_sweep_outputs got O1=%0d O8=%0d exp 0", O1, O8);
    else n_pass++;
    @(negedge CLK); ASYNCRESETN = 1'b1;
    @(posedge CLK); #1;
    n_chk++; if (busy !== 1'b0)
      $display("FAIL release_no_transfer got busy=%b exp 0", busy);
    else n_pass++;
    I_valid = 1'b0;
    n_chk++; if (I_ready !== 1'b1)
      $display("FAIL idle_ready got %b exp 1", I_ready);
    else n_pass++;
  endtask

  task automatic test_single();
    logic [5:0] res; int lat, bc;
    run_word(32'hFFFF_FFFF, res, lat, bc);
    n_chk++; if (res !== 6'd32) $display("FAIL single_result got %0d exp 32", res); else n_pass++;
    n_chk++; if (lat !== 4) $display("FAIL single_latency got %0d exp 4", lat); else n_pass++;
    n_chk++; if (bc !== 4) $display("FAIL single_busy_cycles got %0d exp 4", bc); else n_pass++;
    n_chk++; if (O_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL single_back_to_idle got ov=%b busy=%b exp 0 0", O_valid, busy);
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [31:0] words [3] = '{32'h0000_0000, 32'h8040_2010, 32'h0F0F_00F1};
    int          exp_c [3] = '{0, 4, 13};
    logic [5:0] res; int lat, bc;
    for (int i = 0; i < 3; i++) begin
      run_word(words[i], res, lat, bc);
      n_chk++; if (res !== 6'(exp_c[i]))
        $display("FAIL directed_%0d got %0d exp %0d", i, res, exp_c[i]);
      else n_pass++;
      n_chk++; if (lat !== 4) $display("FAIL directed_lat_%0d got %0d exp 4", i, lat); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [31:0] w; logic [5:0] res; int lat, bc;
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      if (i % 4 == 3) w = w & $urandom & $urandom;
      run_word(w, res, lat, bc);
      n_chk++; if (res !== 6'($countones(w)) || lat !== 4)
        $display("FAIL random_%0h got %0d lat %0d exp %0d lat 4", w, res, lat, $countones(w));
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int lat = 0;
    @(negedge CLK); I = 32'hFFFF_FFFF; I_valid = 1'b1; O_ready = 1'b0;
    @(posedge CLK); #1; I_valid = 1'b0;
    while (!O_valid && lat < 40) begin @(posedge CLK); #1; lat++; end
    n_chk++; if (lat !== 4) $display("FAIL bp_latency got %0d exp 4", lat); else n_pass++;
    for (int c = 0; c < 10; c++) begin
      if (c == 5) I_valid = 1'b1;
      n_chk++; if (O_valid !== 1'b1 || O !== 6'd32 || I_ready !== 1'b0)
        $display("FAIL bp_hold_%0d got ov=%b O=%0d ir=%b exp 1 32 0", c, O_valid, O, I_ready);
      else n_pass++;
      @(posedge CLK); #1;
    end
    I_valid = 1'b0; O_ready = 1'b1;
    @(posedge CLK); #1;
    n_chk++; if (O_valid !== 1'b0 || busy !== 1'b0 || I_ready !== 1'b1)
      $display("FAIL bp_release got ov=%b busy=%b ir=%b exp 0 0 1", O_valid, busy, I_ready);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat = 0;
    @(negedge CLK); I = 32'h0000_00FF; I_valid = 1'b1; O_ready = 1'b1;
    @(posedge CLK); #1; I = 32'h0000_FFFF;
    while (!O_valid && lat < 40) begin @(posedge CLK); #1; lat++; end
    n_chk++; if (O !== 6'd8 || I_ready !== 1'b1)
      $display("FAIL b2b_first got O=%0d ir=%b exp 8 1", O, I_ready);
    else n_pass++;
    @(posedge CLK); #1; I_valid = 1'b0;
    n_chk++; if (busy !== 1'b1 || O_valid !== 1'b0)
      $display("FAIL b2b_no_bubble got busy=%b ov=%b exp 1 0", busy, O_valid);
    else n_pass++;
    lat = 0;
    while (!O_valid && lat < 40) begin @(posedge CLK); #1; lat++; end
    n_chk++; if (O !== 6'd16 || lat !== 4)
      $display("FAIL b2b_second got O=%0d lat %0d exp 16 lat 4", O, lat);
    else n_pass++;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid_run();
    logic [5:0] res; int lat, bc;
    @(negedge CLK); I = 32'hFFFF_FFFF; I_valid = 1'b1; O_ready = 1'b1;
    @(posedge CLK); #1; I_valid = 1'b0;
    repeat (2) @(posedge CLK);
    #3; ASYNCRESETN = 1'b0; #1;
    n_chk++; if (O_valid !== 1'b0 || busy !== 1'b0 || O !== 6'd0 || I_ready !== 1'b0)
      $display("FAIL mid_reset got ov=%b busy=%b O=%0d ir=%b exp 0 0 0 0", O_valid, busy, O, I_ready);
    else n_pass++;
    repeat (2) @(posedge CLK);
    @(negedge CLK); ASYNCRESETN = 1'b1;
    @(posedge CLK); #1;
    run_word(32'h0000_0003, res, lat, bc);
    n_chk++; if (res !== 6'd2 || lat !== 4)
      $display("FAIL after_reset got %0d lat %0d exp 2 lat 4", res, lat);
    else n_pass++;
  endtask

  task automatic test_n1();
    logic [7:0] w;
    for (int i = 0; i < 4; i++) begin
      w = (i == 0) ? 8'hA5 : 8'($urandom);
      @(negedge CLK); I1 = w; I1_valid = 1'b1; O1_ready = 1'b1;
      @(posedge CLK); #1; I1_valid = 1'b0;
      n_chk++; if (busy1 !== 1'b1) $display("FAIL n1_busy got %b exp 1", busy1); else n_pass++;
      @(posedge CLK); #1;
      n_chk++; if (O1_valid !== 1'b1 || O1 !== 4'($countones(w)))
        $display("FAIL n1_result_%0h got ov=%b O=%0d exp 1 %0d", w, O1_valid, O1, $countones(w));
      else n_pass++;
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_n8();
    logic [63:0] w; int lat;
    for (int i = 0; i < 3; i++) begin
      w = (i == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {32'($urandom), 32'($urandom)};
      @(negedge CLK); I8 = w; I8_valid = 1'b1; O8_ready = 1'b1;
      @(posedge CLK); #1; I8_valid = 1'b0; lat = 0;
      while (!O8_valid && lat < 40) begin @(posedge CLK); #1; lat++; end
      n_chk++; if (O8 !== 7'($countones(w)) || lat !== 8)
        $display("FAIL n8_result got %0d lat %0d exp %0d lat 8", O8, lat, $countones(w));
      else n_pass++;
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_n1();
    test_n8();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/popcount_seq.md
Name: popcount_seq

Overview:
- Sequencing controller that computes the population count of an N_BYTES-wide word by time-multiplexing one shared PopCount8 datapath instance, one byte per cycle.
- Accepts words on a valid/ready input channel and accumulates the per-byte counts.
- Presents the total on a valid/ready output channel.
- Sits between a word producer and a consumer wherever a wide popcount is needed without replicating PopCount8 per byte.

Parameters:
- N_BYTES, 4, number of 8-bit chunks per input word; legal range 1..32.
- OUT_WIDTH, 6, width of the result; must be at least clog2(8*N_BYTES+1). The default covers counts 0..32.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- ASYNCRESETN  input  1  asynchronous, active-low reset.
- I  input  8*N_BYTES  input word; byte 0 is I[7:0].
- I_valid  input  1  producer has a word on I.
- I_ready  output  1  block accepts I this cycle.
- O  output  OUT_WIDTH  popcount result.
- O_valid  output  1  O holds a finished result.
- O_ready  input  1  consumer takes O this cycle.
- busy  output  1  high while bytes are being processed (RUN state).

Behaviour:
- Datapath: one PopCount8 instance. Its input is the low byte of the internal shift register. Its 4-bit output is zero-extended to OUT_WIDTH and added to the accumulator. No other popcount logic is permitted.
- State: FSM with states IDLE, RUN and DONE, plus these registers:
  - shreg, 8*N_BYTES bits.
  - acc, OUT_WIDTH bits.
  - idx, clog2(N_BYTES)+1 bits.
- Reset (ASYNCRESETN low, takes effect immediately, independent of CLK):
  - state becomes IDLE; shreg, acc and idx become 0.
  - Outputs: O=0, O_valid=0, busy=0, I_ready=0 while reset is held.
  - Reset asserted mid-RUN or mid-DONE discards the word or result in flight; no partial result is ever presented.
- Reset release: the first rising edge after ASYNCRESETN goes high performs no transfer. I_ready may rise combinationally once reset is deasserted.
- I_ready (combinational) = (state==IDLE) OR (state==DONE AND O_ready).
- Accept: an input transfer occurs on a rising edge where I_valid AND I_ready. On that edge:
  - shreg <= I; acc <= 0; idx <= 0; state <= RUN.
- RUN, on each rising edge:
  - acc <= acc + popcount8(shreg[7:0]).
  - shreg <= shreg >> 8, zero-filled.
  - idx <= idx + 1.
  - When idx == N_BYTES-1, state <= DONE.
  - RUN lasts exactly N_BYTES cycles. I_valid is ignored and I_ready=0 throughout.
- DONE:
  - O_valid=1 and O=acc.
  - O and O_valid stay stable until the output transfer (O_valid AND O_ready on a rising edge).
  - Transfer with I_valid=0 -> IDLE.
  - Transfer with I_valid=1 -> simultaneous accept of the new word and direct entry to RUN (back-to-back, no IDLE bubble).
  - Without a transfer, stay in DONE; backpressure is unbounded.
- O_valid = (state==DONE). O is driven from acc only; O_valid gates its meaning.
- busy = (state==RUN).
- Latency:
  - Accept edge at cycle k -> O_valid high from edge k+N_BYTES onward.
  - Sustained throughput is one word per N_BYTES+1 cycles with O_ready held high.
- Arithmetic: acc never overflows given the OUT_WIDTH constraint. There is no saturation logic.
- O_ready while not in DONE is ignored. I_valid may toggle freely outside accept edges.
- N_BYTES=1: RUN lasts a single cycle and idx terminates at 0.

Test Plan:
- Reset then single word, defaults: I=0xFFFFFFFF accepted at edge k -> busy high for 4 cycles; O_valid at edge k+4 with O=32.
- Directed values with O_ready=1:
  - I=0x00000000 -> O=0.
  - I=0x80402010 -> O=4.
  - I=0x0F0F00F1 -> O=13.
  - Each completes in 4 cycles.
- Backpressure: result O=32 with O_ready=0 for 10 cycles -> O_valid=1 and O=32 held stable, I_ready=0 throughout; O_ready=1 -> transfer, then return to IDLE.
- Back-to-back: I_valid held high with words 0x000000FF then 0x0000FFFF, O_ready=1 -> second word accepted on the same edge the first result (8) transfers; next result 16 exactly 4 edges later.
- Reset mid-operation: assert ASYNCRESETN=0 two cycles into RUN on 0xFFFFFFFF, between clock edges -> O_valid=0, busy=0, O=0 immediately. After release, I=0x00000003 -> O=2 with no residue from the aborted word.
- Parameter sweep: N_BYTES=1, OUT_WIDTH=4, I=0xA5 -> O=4 one edge after accept. N_BYTES=8, OUT_WIDTH=7, all-ones -> O=64 after 8 edges.
